// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit
//
// Write-back stage initiator for the 32x64-bit register file. Retiring results
// from MEM are accepted over a valid/ready handshake into a 2-entry FIFO. The
// ALU/load select is applied on entry. The FIFO head drives the register file
// write port. A per-register pending-write scoreboard lets ID stall reads of
// registers that still have writes in flight.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   MEM-side handshake
//   in_rd, in_regwr       destination register and write flag
//   in_memtoreg           1: in_mem_data, 0: in_alu_result
//   in_alu_result         ALU result
//   in_mem_data           load data
//   wb_stall              hold the FIFO head (no pop, no write)
//   BusW, RW, RegWr       register file write port
//   iss_valid, iss_rd     ID issue of a register-writing instruction
//   iss_regwr             issued instruction writes a register
//   iss_ready             scoreboard can record the issue
//   pend_mask             bit i set while register i has outstanding writes
module wb_writeback_unit #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNTW  = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic        in_regwr,
   input  logic        in_memtoreg,
   input  logic [63:0] in_alu_result,
   input  logic [63:0] in_mem_data,
   input  logic        wb_stall,
   output logic [63:0] BusW,
   output logic [4:0]  RW,
   output logic        RegWr,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic        iss_regwr,
   output logic        iss_ready,
   output logic [31:0] pend_mask
);

   // DEPTH is fixed at 2, so 1-bit pointers wrap naturally.
   localparam int unsigned PtrW  = 1;
   localparam int unsigned FillW = 2;

   logic [63:0]      data_q [DEPTH];
   logic [4:0]       rd_q   [DEPTH];
   logic [DEPTH-1:0] regwr_q;
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [FillW-1:0] fill_q, fill_d;

   logic        push, pop, head_valid;
   logic [63:0] head_data;
   logic [4:0]  head_rd;
   logic        head_regwr;

   logic [CNTW-1:0] cnt_q [31];
   logic [CNTW-1:0] cnt_d [31];
   logic            iss_sat;
   logic            inc;

   // FIFO control and head drive
   always_comb begin
      head_valid = (fill_q != '0);
      // Full check ignores a same-cycle pop: no bypass of the full condition.
      in_ready   = (fill_q < FillW'(DEPTH));
      push       = in_valid & in_ready;
      pop        = head_valid & ~wb_stall;
      head_data  = data_q[rptr_q];
      head_rd    = rd_q[rptr_q];
      head_regwr = regwr_q[rptr_q];
      BusW       = head_valid ? head_data : '0;
      RW         = head_valid ? head_rd : '0;
      // X31 is never written to the register file; such entries still pop.
      RegWr      = pop & head_regwr & (head_rd != 5'd31);
      fill_d     = fill_q;
      if (push && !pop) begin
         fill_d = fill_q + FillW'(1);
      end else if (pop && !push) begin
         fill_d = fill_q - FillW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         fill_q  <= '0;
         regwr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            rd_q[i]   <= '0;
         end
      end else begin
         fill_q <= fill_d;
         if (push) begin
            data_q[wptr_q]  <= in_memtoreg ? in_mem_data : in_alu_result;
            rd_q[wptr_q]    <= in_rd;
            regwr_q[wptr_q] <= in_regwr;
            wptr_q          <= wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
      end
   end

   // Pending-write scoreboard; register 31 has no counter.
   always_comb begin
      iss_sat = 1'b0;
      for (int i = 0; i < 31; i++) begin
         if (iss_rd == 5'(i) && cnt_q[i] == '1) begin
            iss_sat = 1'b1;
         end
      end
      iss_ready = ~(iss_regwr & iss_sat);
      inc       = iss_valid & iss_ready & iss_regwr & (iss_rd != 5'd31);
      pend_mask = '0;
      for (int i = 0; i < 31; i++) begin
         cnt_d[i]     = cnt_q[i];
         pend_mask[i] = (cnt_q[i] != '0);
         if (inc && iss_rd == 5'(i) && !(RegWr && head_rd == 5'(i))) begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         end else if (RegWr && head_rd == 5'(i) && !(inc && iss_rd == 5'(i))
                      && cnt_q[i] != '0) begin
            // A write for a register with no pending count holds at zero.
            cnt_d[i] = cnt_q[i] - CNTW'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 31; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 31; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_wb_writeback_unit.sv
module tb_wb_writeback_unit;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        in_valid, in_ready, in_regwr, in_memtoreg;
   logic [4:0]  in_rd;
   logic [63:0] in_alu_result, in_mem_data;
   logic        wb_stall;
   logic [63:0] BusW;
   logic [4:0]  RW;
   logic        RegWr;
   logic        iss_valid, iss_regwr, iss_ready;
   logic [4:0]  iss_rd;
   logic [31:0] pend_mask;

   always #5 Clk = ~Clk;

   wb_writeback_unit #(.DEPTH(2), .CNTW(2)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_regwr      (in_regwr),
      .in_memtoreg   (in_memtoreg),
      .in_alu_result (in_alu_result),
      .in_mem_data   (in_mem_data),
      .wb_stall      (wb_stall),
      .BusW          (BusW),
      .RW            (RW),
      .RegWr         (RegWr),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_regwr     (iss_regwr),
      .iss_ready     (iss_ready),
      .pend_mask     (pend_mask)
   );

   typedef struct {
      logic [4:0]  rd;
      logic        regwr;
      logic [63:0] data;
   } ent_t;

   // Reference model: queue of buffered writes and outstanding-write counts.
   ent_t       fq[$];
   int         cnt[32];
   logic [4:0] iq[$];
   logic [4:0] wr_log[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_proto = 0;
   logic       acc, issued;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      iq.delete();
      for (int i = 0; i < 32; i++) cnt[i] = 0;
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_rd         = '0;
      in_regwr      = 1'b0;
      in_memtoreg   = 1'b0;
      in_alu_result = '0;
      in_mem_data   = '0;
      wb_stall      = 1'b0;
      iss_valid     = 1'b0;
      iss_rd        = '0;
      iss_regwr     = 1'b0;
   endtask

   task automatic set_in(input logic [4:0] rd, input logic regwr, input logic m2r,
                         input logic [63:0] alu, input logic [63:0] mem);
      in_valid      = 1'b1;
      in_rd         = rd;
      in_regwr      = regwr;
      in_memtoreg   = m2r;
      in_alu_result = alu;
      in_mem_data   = mem;
   endtask

   // Entered at posedge+1 with inputs driven; checks mid-cycle, then
   // advances the model across the next edge and returns at posedge+1.
   task automatic cycle();
      logic        hv, e_ready, e_wr, e_iss;
      logic [31:0] e_mask;
      ent_t        h, n;
      #4;
      hv = (fq.size() != 0);
      if (hv) h = fq[0];
      else begin
         h.rd = '0; h.regwr = 1'b0; h.data = '0;
      end
      e_ready = (fq.size() < 2);
      e_wr    = hv && !wb_stall && h.regwr && (h.rd != 5'd31);
      e_mask  = '0;
      for (int i = 0; i < 31; i++) e_mask[i] = (cnt[i] != 0);
      e_iss = !(iss_regwr && iss_rd != 5'd31 && cnt[iss_rd] == 3);
      check_eq("in_ready", in_ready, e_ready);
      check_eq("RegWr", RegWr, e_wr);
      check_eq("BusW", BusW, h.data);
      check_eq("RW", RW, h.rd);
      check_eq("pend_mask", pend_mask, e_mask);
      check_eq("iss_ready", iss_ready, e_iss);
      if (RegWr) wr_log.push_back(RW);
      @(posedge Clk);
      acc    = in_valid && e_ready;
      issued = iss_valid && e_iss && iss_regwr && (iss_rd != 5'd31);
      if (issued) cnt[iss_rd]++;
      if (e_wr) begin
         if (cnt[h.rd] == 0) n_proto++;
         else cnt[h.rd]--;
      end
      if (hv && !wb_stall) void'(fq.pop_front());
      if (acc) begin
         n.rd    = in_rd;
         n.regwr = in_regwr;
         n.data  = in_memtoreg ? in_mem_data : in_alu_result;
         fq.push_back(n);
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic holding, from_iq;
      idle();
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_RegWr", RegWr, 0);
      check_eq("rst_BusW", BusW, 0);
      check_eq("rst_RW", RW, 0);
      check_eq("rst_pend_mask", pend_mask, 0);
      check_eq("rst_iss_ready", iss_ready, 1);
      Reset_n = 1'b1;
      cycle();

      // 1: single accept, written the following cycle (no issue: counter holds at 0)
      set_in(5'd5, 1'b1, 1'b0, 64'h1234, 64'h9999);
      cycle();
      idle();
      check_eq("t1_RegWr", RegWr, 1);
      check_eq("t1_RW", RW, 5);
      check_eq("t1_BusW", BusW, 64'h1234);
      cycle();
      check_eq("t1_RegWr_after", RegWr, 0);

      // 2: load select
      set_in(5'd6, 1'b1, 1'b1, 64'h5, 64'hDEADBEEF_00000001);
      cycle();
      idle();
      check_eq("t2_BusW", BusW, 64'hDEADBEEF_00000001);
      cycle();

      // 3: X31 and no-write entries occupy slots but never write
      set_in(5'd31, 1'b1, 1'b0, 64'hAA, 64'h0);
      cycle();
      set_in(5'd3, 1'b0, 1'b0, 64'hBB, 64'h0);
      check_eq("t3_RW31", RW, 31);
      check_eq("t3_RegWr31", RegWr, 0);
      cycle();
      idle();
      check_eq("t3_RW3", RW, 3);
      check_eq("t3_RegWr3", RegWr, 0);
      cycle();
      check_eq("t3_empty", in_ready, 1);
      check_eq("t3_mask", pend_mask, 0);

      // 4: backpressure then in-order drain
      wr_log.delete();
      wb_stall = 1'b1;
      set_in(5'd1, 1'b1, 1'b0, 64'h111, 64'h0);
      cycle();
      set_in(5'd2, 1'b1, 1'b0, 64'h222, 64'h0);
      cycle();
      set_in(5'd3, 1'b1, 1'b0, 64'h333, 64'h0);
      check_eq("t4_full", in_ready, 0);
      check_eq("t4_stalled_RegWr", RegWr, 0);
      cycle();
      wb_stall = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (acc) break;
      end
      idle();
      repeat (2) cycle();
      check_eq("t4_nwrites", wr_log.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < wr_log.size()) check_eq("t4_order", wr_log[k], 5'(k + 1));
      end

      // 5: scoreboard saturation, drain and same-cycle issue+write
      iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd7;
      repeat (3) cycle();
      check_eq("t5_iss_ready_sat", iss_ready, 0);
      check_eq("t5_pend7", pend_mask[7], 1);
      cycle();
      idle();
      for (int k = 0; k < 3; k++) begin
         set_in(5'd7, 1'b1, 1'b0, 64'(k), 64'h0);
         cycle();
      end
      idle();
      cycle();
      check_eq("t5_pend7_clear", pend_mask[7], 0);
      iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd7;
      cycle();
      idle();
      set_in(5'd7, 1'b1, 1'b0, 64'h77, 64'h0);
      cycle();
      idle();
      iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd7;
      check_eq("t5_same_RegWr", RegWr, 1);
      cycle();
      idle();
      check_eq("t5_pend7_held", pend_mask[7], 1);
      set_in(5'd7, 1'b1, 1'b0, 64'h78, 64'h0);
      cycle();
      idle();
      repeat (2) cycle();
      check_eq("t5_pend7_final", pend_mask[7], 0);

      // 6: asynchronous reset with two entries queued and counters nonzero
      wb_stall = 1'b1;
      iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd12;
      set_in(5'd9, 1'b1, 1'b0, 64'h99, 64'h0);
      cycle();
      set_in(5'd10, 1'b1, 1'b0, 64'hA0, 64'h0);
      cycle();
      idle();
      wb_stall = 1'b1;
      iss_regwr = 1'b1; iss_rd = 5'd12;
      cycle();
      check_eq("t6_pre_full", in_ready, 0);
      #2;
      Reset_n = 1'b0;
      #1;
      check_eq("t6_in_ready", in_ready, 1);
      check_eq("t6_RegWr", RegWr, 0);
      check_eq("t6_BusW", BusW, 0);
      check_eq("t6_RW", RW, 0);
      check_eq("t6_pend_mask", pend_mask, 0);
      check_eq("t6_iss_ready", iss_ready, 1);
      model_reset();
      wb_stall = 1'b0;
      @(posedge Clk);
      #1;
      check_eq("t6_hold_RegWr", RegWr, 0);
      Reset_n = 1'b1;
      idle();
      repeat (2) cycle();

      // Randomized traffic: writes come from previously issued destinations
      holding = 1'b0;
      from_iq = 1'b0;
      for (int c = 0; c < 600; c++) begin
         wb_stall = ($urandom_range(0, 3) == 0);
         if (!holding) begin
            if ($urandom_range(0, 2) != 0) begin
               set_in(5'd0, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                      {$urandom, $urandom});
               if (iq.size() != 0 && $urandom_range(0, 3) != 0) begin
                  in_rd = iq[0]; in_regwr = 1'b1; from_iq = 1'b1;
               end else begin
                  from_iq = 1'b0;
                  if ($urandom_range(0, 1) == 1) begin
                     in_rd = 5'd31; in_regwr = 1'b1;
                  end else begin
                     in_rd = 5'($urandom_range(0, 31)); in_regwr = 1'b0;
                  end
               end
            end else begin
               in_valid = 1'b0;
            end
         end
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd    = 5'($urandom_range(0, 31));
         iss_regwr = ($urandom_range(0, 3) != 0);
         cycle();
         if (issued) iq.push_back(iss_rd);
         if (in_valid && acc) begin
            if (from_iq) void'(iq.pop_front());
            holding = 1'b0;
         end else begin
            holding = in_valid;
         end
      end
      idle();
      repeat (4) cycle();

      $display("note: %0d write-backs hit a register with no pending count", n_proto);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
